// File: rtl/writeback_arbiter_pkg.sv
// Shared encodings, FSM state type and one-hot helpers for the write-back arbiter.
// The DEST_SEL_* values are the same ones the destination-value mux decodes.
package writeback_arbiter_pkg;

   localparam int WB_WORD_SIZE_DEFAULT = 32;

   localparam logic [1:0] DEST_SEL_ADD    = 2'b00;
   localparam logic [1:0] DEST_SEL_MULT   = 2'b01;
   localparam logic [1:0] DEST_SEL_MULADD = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } wb_state_e;

   function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
      case (sel)
         DEST_SEL_MULT:   return 3'b010;
         DEST_SEL_MULADD: return 3'b100;
         default:         return 3'b001;
      endcase
   endfunction

   function automatic logic [1:0] onehot_to_sel(input logic [2:0] oh);
      if (oh[2]) return DEST_SEL_MULADD;
      if (oh[1]) return DEST_SEL_MULT;
      return DEST_SEL_ADD;
   endfunction

   // First eligible requester in the search order a, b, c.
   function automatic logic [2:0] first_of(input logic [2:0] eff,
                                           input logic [1:0] a,
                                           input logic [1:0] b,
                                           input logic [1:0] c);
      if (|(eff & sel_to_onehot(a))) return sel_to_onehot(a);
      if (|(eff & sel_to_onehot(b))) return sel_to_onehot(b);
      if (|(eff & sel_to_onehot(c))) return sel_to_onehot(c);
      return 3'b000;
   endfunction

endpackage

// File: rtl/writeback_arbiter_rr_arbiter3.sv
// 3-way arbiter: round-robin after ptr_i, or fixed MULADD > MULT > ADD when
// WB_ARB_FIXED_PRIO_EN is defined. Masked requesters are never granted.
module rr_arbiter3
   import writeback_arbiter_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic [2:0] mask_i,
   input  logic [1:0] ptr_i,
   output logic [2:0] gnt_o
);

   logic [2:0] eff;
   assign eff = req_i & ~mask_i;

`ifdef WB_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   always_comb begin
      gnt_o = first_of(eff, DEST_SEL_MULADD, DEST_SEL_MULT, DEST_SEL_ADD);
   end
`else
   // ptr_i names the last committed unit; the search starts just after it.
   always_comb begin
      case (ptr_i)
         DEST_SEL_ADD:  gnt_o = first_of(eff, DEST_SEL_MULT,   DEST_SEL_MULADD, DEST_SEL_ADD);
         DEST_SEL_MULT: gnt_o = first_of(eff, DEST_SEL_MULADD, DEST_SEL_ADD,    DEST_SEL_MULT);
         default:       gnt_o = first_of(eff, DEST_SEL_ADD,    DEST_SEL_MULT,   DEST_SEL_MULADD);
      endcase
   end
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter for ADD/MULT/MULADD results toward the register-file port.
// Build option WB_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int WORD_SIZE  = WB_WORD_SIZE_DEFAULT,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  add_valid,
   input  logic                  mult_valid,
   input  logic                  muladd_valid,
   input  logic [REG_ADDR_W-1:0] add_dest,
   input  logic [REG_ADDR_W-1:0] mult_dest,
   input  logic [REG_ADDR_W-1:0] muladd_dest,
   input  logic [WORD_SIZE-1:0]  add_destval,
   input  logic [WORD_SIZE-1:0]  mult_destval,
   input  logic [WORD_SIZE-1:0]  muladd_destval,
   output logic                  add_ready,
   output logic                  mult_ready,
   output logic                  muladd_ready,
   input  logic                  wb_ready,
   output logic [1:0]            dest_sel,
   output logic                  wb_en,
   output logic [REG_ADDR_W-1:0] wb_addr
);

   wb_state_e             state_q, state_d;
   logic [1:0]            sel_q, sel_d;
   logic [REG_ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]            req, mask, gnt, rdy;
   logic [1:0]            gnt_sel, ptr_eff;
   logic [REG_ADDR_W-1:0] gnt_dest;
   logic                  commit;

   assign req    = {muladd_valid, mult_valid, add_valid};
   assign wb_en  = (state_q == ST_HOLD);
   assign commit = wb_en & wb_ready & rst_n;
   // The committing unit's valid still describes the item being written.
   assign mask   = commit ? sel_to_onehot(sel_q) : 3'b000;

`ifdef WB_ARB_FIXED_PRIO_EN
   assign ptr_eff = DEST_SEL_MULADD;
`else
   logic [1:0] ptr_q;

   assign ptr_eff = commit ? sel_q : ptr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= DEST_SEL_MULADD;
      end else if (commit) begin
         ptr_q <= sel_q;
      end
   end
`endif

   rr_arbiter3 u_arb (
      .req_i  (req),
      .mask_i (mask),
      .ptr_i  (ptr_eff),
      .gnt_o  (gnt)
   );

   assign gnt_sel = onehot_to_sel(gnt);

   always_comb begin
      case (gnt_sel)
         DEST_SEL_MULT:   gnt_dest = mult_dest;
         DEST_SEL_MULADD: gnt_dest = muladd_dest;
         default:         gnt_dest = add_dest;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               state_d = ST_HOLD;
               sel_d   = gnt_sel;
               addr_d  = gnt_dest;
            end
         end
         ST_HOLD: begin
            if (commit) begin
               if (|gnt) begin
                  sel_d  = gnt_sel;
                  addr_d = gnt_dest;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= DEST_SEL_ADD;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
      end
   end

   assign dest_sel     = sel_q;
   assign wb_addr      = addr_q;
   assign rdy          = commit ? sel_to_onehot(sel_q) : 3'b000;
   assign add_ready    = rdy[0];
   assign mult_ready   = rdy[1];
   assign muladd_ready = rdy[2];

   // Source protocol monitors: a pending item must not move until its ready.
   logic [REG_ADDR_W-1:0] dest_a [3];
   logic [WORD_SIZE-1:0]  dval_a [3];

   assign dest_a[0] = add_dest;
   assign dest_a[1] = mult_dest;
   assign dest_a[2] = muladd_dest;
   assign dval_a[0] = add_destval;
   assign dval_a[1] = mult_destval;
   assign dval_a[2] = muladd_destval;

   for (genvar u = 0; u < 3; u++) begin : g_src_chk
      a_src_stable: assert property (@(posedge clk) disable iff (!rst_n)
         (req[u] && !rdy[u]) |=> (req[u] && $stable(dest_a[u]) && $stable(dval_a[u])));
   end

   a_sel_legal: assert property (@(posedge clk) disable iff (!rst_n) dest_sel != 2'b11);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed scenarios plus random traffic.
module tb_writeback_arbiter;

   localparam int AW = 4;
   localparam int WS = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    vld;
   logic [AW-1:0] dst [3];
   logic [WS-1:0] dv  [3];
   logic          wb_ready;
   logic          add_ready, mult_ready, muladd_ready, wb_en;
   logic [1:0]    dest_sel;
   logic [AW-1:0] wb_addr;
   logic [2:0]    rdy;

   int tests_run = 0;
   int fails     = 0;

   typedef struct packed {
      logic [1:0]    sel;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t          exp_q [$];
   exp_t          e;
   logic [AW-1:0] unit_q [3][$];

   assign rdy = {muladd_ready, mult_ready, add_ready};

   always #5 clk = ~clk;

   writeback_arbiter #(.WORD_SIZE(WS), .REG_ADDR_W(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .add_valid      (vld[0]),
      .mult_valid     (vld[1]),
      .muladd_valid   (vld[2]),
      .add_dest       (dst[0]),
      .mult_dest      (dst[1]),
      .muladd_dest    (dst[2]),
      .add_destval    (dv[0]),
      .mult_destval   (dv[1]),
      .muladd_destval (dv[2]),
      .add_ready      (add_ready),
      .mult_ready     (mult_ready),
      .muladd_ready   (muladd_ready),
      .wb_ready       (wb_ready),
      .dest_sel       (dest_sel),
      .wb_en          (wb_en),
      .wb_addr        (wb_addr)
   );

   function automatic exp_t mk(input logic [1:0] s, input logic [AW-1:0] a);
      exp_t r;
      r.sel  = s;
      r.addr = a;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Leaves the bench in the first cycle after reset release, inputs idle.
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      vld = '0; wb_ready = 1'b0;
      for (int u = 0; u < 3; u++) begin dst[u] = '0; dv[u] = '0; end
      tick();
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vld = 3'b111; wb_ready = 1'b1;
      for (int u = 0; u < 3; u++) begin dst[u] = 4'hF; dv[u] = '0; end
      tick(); tick(); settle();
      tests_run++;
      if (wb_en !== 1'b0) begin fails++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
      tests_run++;
      if (dest_sel !== 2'b00) begin fails++; $display("FAIL reset_dest_sel: got %b want 00", dest_sel); end
      tests_run++;
      if (wb_addr !== '0) begin fails++; $display("FAIL reset_wb_addr: got %0d want 0", wb_addr); end
      tests_run++;
      if (rdy !== 3'b000) begin fails++; $display("FAIL reset_readies: got %b want 000", rdy); end
   endtask

   task automatic test_round_robin();
      int first, last;
      do_reset();
      vld = 3'b111; dst[0] = 4'd1; dst[1] = 4'd2; dst[2] = 4'd3; wb_ready = 1'b1;
      exp_q.push_back(mk(2'd0, 4'd1)); exp_q.push_back(mk(2'd1, 4'd2));
      exp_q.push_back(mk(2'd2, 4'd3)); exp_q.push_back(mk(2'd0, 4'd1));
      first = -1; last = -1;
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         settle();
         if (rdy != 3'b000) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rdy !== (3'b001 << e.sel) || dest_sel !== e.sel || wb_addr !== e.addr) begin
               fails++;
               $display("FAIL rr_commit: rdy=%b sel=%0d addr=%0d, want rdy=%b sel=%0d addr=%0d",
                        rdy, dest_sel, wb_addr, 3'b001 << e.sel, e.sel, e.addr);
            end
            if (first < 0) first = c;
            last = c;
         end
         tick();
      end
      tests_run++;
      if (exp_q.size() != 0 || last - first != 3) begin
         fails++;
         $display("FAIL rr_timing: %0d commits left, span %0d cycles, want 0 left, span 3",
                  exp_q.size(), last - first);
      end
   endtask

   task automatic test_stall();
      int pulses;
      do_reset();
      vld = 3'b010; dst[1] = 4'd5; wb_ready = 1'b0;
      exp_q.push_back(mk(2'd1, 4'd5));
      pulses = 0;
      for (int c = 0; c < 7; c++) begin
         if (c == 4) wb_ready = 1'b1;
         if (c == 5) begin vld = 3'b000; wb_ready = 1'b0; end
         settle();
         if (c >= 1 && c <= 4) begin
            tests_run++;
            if (wb_en !== 1'b1 || dest_sel !== 2'b01 || wb_addr !== 4'd5) begin
               fails++;
               $display("FAIL stall_hold c%0d: wb_en=%b sel=%b addr=%0d, want 1 01 5",
                        c, wb_en, dest_sel, wb_addr);
            end
         end
         tests_run++;
         if (rdy !== ((c == 4) ? 3'b010 : 3'b000)) begin
            fails++;
            $display("FAIL stall_ready c%0d: got %b want %b", c, rdy, (c == 4) ? 3'b010 : 3'b000);
         end
         if (rdy != 3'b000) begin
            pulses++;
            tests_run++;
            if (exp_q.size() == 0) begin
               fails++; $display("FAIL stall_dup: ready %b with nothing pending", rdy);
            end else begin
               e = exp_q.pop_front();
               if (wb_addr !== e.addr) begin
                  fails++; $display("FAIL stall_addr: got %0d want %0d", wb_addr, e.addr);
               end
            end
         end
         if (c >= 5) begin
            tests_run++;
            if (wb_en !== 1'b0) begin fails++; $display("FAIL stall_idle c%0d: wb_en %b want 0", c, wb_en); end
         end
         tick();
      end
      tests_run++;
      if (pulses != 1) begin fails++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_single_unit();
      int dlist [4];
      int idx, got, prev_c;
      bit seen_prev;
      dlist = '{3, 7, 9, 12};
      do_reset();
      idx = 0; got = 0; prev_c = -1; seen_prev = 1'b0;
      vld = 3'b001; dst[0] = AW'(dlist[0]); dv[0] = $urandom; wb_ready = 1'b1;
      exp_q.push_back(mk(2'd0, AW'(dlist[0])));
      for (int c = 0; c < 20 && got < 4; c++) begin
         if (seen_prev) begin
            idx++;
            dst[0] = AW'(dlist[idx]); dv[0] = $urandom;
            exp_q.push_back(mk(2'd0, AW'(dlist[idx])));
            seen_prev = 1'b0;
         end
         settle();
         if (rdy != 3'b000) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               fails++; $display("FAIL single_dup: ready %b with nothing pending", rdy);
            end else begin
               e = exp_q.pop_front();
               if (rdy !== 3'b001 || dest_sel !== 2'b00 || wb_addr !== e.addr) begin
                  fails++;
                  $display("FAIL single_commit: rdy=%b sel=%b addr=%0d, want 001 00 %0d",
                           rdy, dest_sel, wb_addr, e.addr);
               end
            end
            if (prev_c >= 0) begin
               tests_run++;
               if (c - prev_c != 2) begin fails++; $display("FAIL single_gap: got %0d want 2", c - prev_c); end
            end
            prev_c = c; got++;
            seen_prev = (got < 4);
         end
         tick();
      end
      tests_run++;
      if (got != 4 || exp_q.size() != 0) begin
         fails++; $display("FAIL single_count: got %0d commits want 4, %0d left", got, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      vld = 3'b001; dst[0] = 4'd6; wb_ready = 1'b0;
      exp_q.push_back(mk(2'd0, 4'd6));
      settle(); tick();
      settle();
      tests_run++;
      if (wb_en !== 1'b1 || wb_addr !== 4'd6) begin
         fails++; $display("FAIL rsthold_grant: wb_en=%b addr=%0d want 1 6", wb_en, wb_addr);
      end
      tick();
      rst_n = 1'b0; wb_ready = 1'b1;
      settle();
      tests_run++;
      if (rdy !== 3'b000) begin fails++; $display("FAIL rsthold_noready: got %b want 000", rdy); end
      tick();
      rst_n = 1'b1;
      settle();
      tests_run++;
      if (wb_en !== 1'b0 || dest_sel !== 2'b00 || wb_addr !== '0 || rdy !== 3'b000) begin
         fails++;
         $display("FAIL rsthold_cleared: wb_en=%b sel=%b addr=%0d rdy=%b, want 0 00 0 000",
                  wb_en, dest_sel, wb_addr, rdy);
      end
      tick();
      settle();
      tests_run++;
      e = exp_q.pop_front();
      if (rdy !== 3'b001 || wb_addr !== e.addr) begin
         fails++; $display("FAIL rsthold_recommit: rdy=%b addr=%0d want 001 %0d", rdy, wb_addr, e.addr);
      end
      tick();
      vld = 3'b000;
      settle();
      tests_run++;
      if (wb_en !== 1'b0) begin fails++; $display("FAIL rsthold_after: wb_en %b want 0", wb_en); end
   endtask

`ifdef WB_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      int k;
      do_reset();
      vld = 3'b111; dst[0] = 4'd1; dst[1] = 4'd2; dst[2] = 4'd3; wb_ready = 1'b1;
      exp_q.push_back(mk(2'd2, 4'd3)); exp_q.push_back(mk(2'd1, 4'd2));
      exp_q.push_back(mk(2'd2, 4'd3)); exp_q.push_back(mk(2'd1, 4'd2));
      exp_q.push_back(mk(2'd2, 4'd3)); exp_q.push_back(mk(2'd0, 4'd1));
      k = 0;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         settle();
         if (rdy != 3'b000) begin
            e = exp_q.pop_front(); k++;
            tests_run++;
            if (rdy !== (3'b001 << e.sel) || dest_sel !== e.sel || wb_addr !== e.addr) begin
               fails++;
               $display("FAIL fixed_commit %0d: rdy=%b sel=%0d addr=%0d, want sel=%0d addr=%0d",
                        k, rdy, dest_sel, wb_addr, e.sel, e.addr);
            end
            if (k == 4) vld[1] = 1'b0;
            if (k == 5) vld[2] = 1'b0;
            if (k == 6) vld[0] = 1'b0;
         end
         tick();
      end
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL fixed_left: %0d commits missing", exp_q.size()); end
   endtask
`endif

   task automatic test_random();
      bit done [3];
      logic [AW-1:0] a;
      int pend;
      do_reset();
      for (int u = 0; u < 3; u++) begin unit_q[u].delete(); done[u] = 1'b0; end
      for (int c = 0; c < 10100; c++) begin
         for (int u = 0; u < 3; u++) begin
            if (done[u]) begin
               done[u] = 1'b0;
               vld[u]  = 1'b0;
            end
            if (!vld[u] && c < 10000 && $urandom_range(0, 2) == 0) begin
               vld[u] = 1'b1;
               dst[u] = AW'($urandom);
               dv[u]  = $urandom;
               unit_q[u].push_back(dst[u]);
            end
         end
         wb_ready = (c >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
         settle();
         tests_run++;
         if ($countones(rdy) > 1 || dest_sel === 2'b11) begin
            fails++; $display("FAIL rand_outputs c%0d: rdy=%b sel=%b", c, rdy, dest_sel);
         end
         for (int u = 0; u < 3; u++) begin
            if (rdy[u]) begin
               tests_run++;
               if (unit_q[u].size() == 0) begin
                  fails++; $display("FAIL rand_dup c%0d: unit %0d ready with nothing pending", c, u);
               end else begin
                  a = unit_q[u].pop_front();
                  if (wb_addr !== a || dest_sel !== 2'(u) || !vld[u]) begin
                     fails++;
                     $display("FAIL rand_commit c%0d: unit %0d addr=%0d sel=%0d, want addr=%0d sel=%0d",
                              c, u, wb_addr, dest_sel, a, u);
                  end
               end
               done[u] = 1'b1;
            end
         end
         tick();
      end
      pend = unit_q[0].size() + unit_q[1].size() + unit_q[2].size();
      tests_run++;
      if (pend != 0) begin fails++; $display("FAIL rand_lost: %0d writes never committed, want 0", pend); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; vld = '0; wb_ready = 1'b0;
      for (int u = 0; u < 3; u++) begin dst[u] = '0; dv[u] = '0; end
      test_reset();
      test_round_robin();
      test_stall();
      test_single_unit();
      test_reset_mid_hold();
`ifdef WB_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
